life_gen_scheduler: RTL and testbench
=====================================

// Module: life_gen_scheduler
// PURPOSE
//   Sequences the Game-of-Life board engine: decides when a generation runs,
//   sweeps cell indices for the seed/copy/evaluate phases and tells the pixel
//   path which board to display. Sits between vga_sync (frame timing), the user
//   run/step/seed controls and the 8x8 board storage/update datapath.
//   Replaces ad-hoc vsync clocking: everything runs on clk, one request per frame.
// PARAMETERS
//   CELL_BITS  6   log2(cell count); board = 2**CELL_BITS cells (64)
//   GEN_BITS   16  width of generation counter
//   DIV_BITS   4   width of frame divider / speed input
// PORTS
//   clk        in   1          pixel clock
//   reset      in   1          synchronous, active-high
//   vsync      in   1          raw vsync from vga_sync (clk domain)
//   run        in   1          level: free-running generations when 1
//   step       in   1          1-cycle pulse: request one generation
//   seed_req   in   1          1-cycle pulse: reload seed pattern
//   speed      in   DIV_BITS   frame ticks per generation minus 1
//   cell_idx   out  CELL_BITS  cell address driven to datapath
//   seed_we    out  1          write seed value at cell_idx
//   copy_we    out  1          copy curr->prev at cell_idx
//   eval_we    out  1          write next-state of cell_idx into curr
//   show_prev  out  1          display select: 1=prev board, 0=curr board
//   busy       out  1          1 while any sweep in progress
//   gen_count  out  GEN_BITS   completed generations since last seed
//   gen_done   out  1          1-cycle pulse at end of each generation
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, divider 0, step_pend 0, seed_pend 1
//   (board seeded at first frame tick after reset).
// - frame_tick = vsync & ~vsync_q (vsync_q registered); one tick per rising
//   edge regardless of vsync high duration.
// - Divider: on each tick in run mode, if div_cnt >= speed -> launch gen,
//   div_cnt<=0; else div_cnt+1. Ticks with run=0 leave div_cnt unchanged.
// - Requests: step/seed_req set step_pend/seed_pend (1-deep, duplicates merge),
//   accepted in any state, never lost. step ignored when run=1.
// - States: IDLE, SEED, COPY, EVAL.
//   IDLE -> SEED on tick if seed_pend (clear seed_pend, gen_count<=0).
//   IDLE -> COPY on tick if !seed_pend and (divider launch or step_pend);
//     clears step_pend. Seed has priority; losing request waits for next tick.
//   Ticks outside IDLE are ignored (divider does not advance).
//   SEED/COPY/EVAL: cell_idx counts 0..2**CELL_BITS-1, one cell per cycle,
//     matching *_we high every cycle of the sweep; SEED->IDLE, COPY->EVAL,
//     EVAL->IDLE after last index. cell_idx returns to 0 in IDLE.
// - Latency: tick detected cycle t -> first write (cell_idx=0) at t+1.
//   Generation = 2*2**CELL_BITS cycles (128); fits in one vblank-free frame.
// - show_prev=1 for exactly the EVAL cycles, else 0 (display never sees a
//   half-written curr board).
// - gen_done pulses and gen_count increments (mod 2**GEN_BITS) in the cycle
//   after last EVAL write; busy=0 in that same cycle.
// - run dropped mid-generation: generation completes; no further launches.
// - reset mid-sweep: next cycle all outputs 0, state IDLE, seed_pend 1.
// TESTING
//   1 reset, one vsync edge -> seed_we high 64 cycles, cell_idx 0..63,
//     gen_count=0, no gen_done, copy_we/eval_we never high.
//   2 run=1 speed=0, 3 frames -> each: 64 copy_we, 64 eval_we with
//     show_prev=1, gen_done once; gen_count 1,2,3.
//   3 run=1 speed=3, 12 frame ticks -> exactly 3 generations, on ticks 4,8,12.
//   4 run=0, step pulse, 3 ticks -> exactly 1 generation at first tick;
//     vsync held high 1000 cycles -> still one tick.
//   5 seed_req+step same cycle during EVAL -> current gen finishes (count N+1),
//     next tick SEED (count 0), following tick one gen (count 1).
//   6 reset during COPY at cell_idx=20 -> next cycle copy_we=0, cell_idx=0,
//     busy=0, gen_count=0; next tick runs SEED.

Source files
------------

// File: rtl/life_gen_scheduler.sv
// ----------------------------------------------------------------------------
// life_gen_scheduler
//   Sequences the Game-of-Life board engine. It turns vsync edges into frame
//   ticks, decides on which tick a generation (or a seed reload) runs, and
//   sweeps the cell index for the seed, copy and evaluate phases. It also
//   tells the pixel path which board is safe to display.
//
// Ports
//   i_clk        pixel clock
//   i_reset      synchronous, active-high reset
//   i_vsync      raw vsync from vga_sync (i_clk domain)
//   i_run        level: free-running generations while high
//   i_step       1-cycle pulse: request one generation (ignored while i_run)
//   i_seed_req   1-cycle pulse: reload the seed pattern
//   i_speed      frame ticks per generation minus 1
//   o_cell_idx   cell address to the board datapath
//   o_seed_we    write seed value at o_cell_idx
//   o_copy_we    copy curr->prev at o_cell_idx
//   o_eval_we    write next state of o_cell_idx into curr
//   o_show_prev  display select: 1 = prev board, 0 = curr board
//   o_busy       high while any sweep is in progress
//   o_gen_count  completed generations since the last seed
//   o_gen_done   1-cycle pulse after the last evaluate write
// ----------------------------------------------------------------------------
module life_gen_scheduler #(
    parameter int CELL_BITS = 6,
    parameter int GEN_BITS  = 16,
    parameter int DIV_BITS  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_vsync,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_seed_req,
    input  logic [DIV_BITS-1:0]  i_speed,
    output logic [CELL_BITS-1:0] o_cell_idx,
    output logic                 o_seed_we,
    output logic                 o_copy_we,
    output logic                 o_eval_we,
    output logic                 o_show_prev,
    output logic                 o_busy,
    output logic [GEN_BITS-1:0]  o_gen_count,
    output logic                 o_gen_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_COPY = 2'd2,
        S_EVAL = 2'd3
    } state_t;

    localparam logic [CELL_BITS-1:0] LAST_IDX = '1;

    state_t                r_state;
    logic                  r_vsync_q;
    logic [DIV_BITS-1:0]   r_div_cnt;
    logic                  r_step_pend;
    logic                  r_seed_pend;
    logic [CELL_BITS-1:0]  r_cell_idx;
    logic                  r_seed_we;
    logic                  r_copy_we;
    logic                  r_eval_we;
    logic                  r_show_prev;
    logic                  r_busy;
    logic [GEN_BITS-1:0]   r_gen_count;
    logic                  r_gen_done;

    logic w_tick;
    logic w_step_now;
    logic w_seed_now;
    logic w_div_launch;
    logic w_last;

    // One tick per rising vsync edge, however long vsync stays high.
    assign w_tick       = i_vsync & ~r_vsync_q;
    // Requests arriving this cycle merge with the pending flags so a pulse
    // coinciding with a tick is acted on immediately rather than lost.
    assign w_step_now   = r_step_pend | (i_step & ~i_run);
    assign w_seed_now   = r_seed_pend | i_seed_req;
    assign w_div_launch = i_run && (r_div_cnt >= i_speed);
    assign w_last       = (r_cell_idx == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_vsync_q   <= 1'b0;
            r_div_cnt   <= '0;
            r_step_pend <= 1'b0;
            r_seed_pend <= 1'b1;   // board gets seeded on the first tick
            r_cell_idx  <= '0;
            r_seed_we   <= 1'b0;
            r_copy_we   <= 1'b0;
            r_eval_we   <= 1'b0;
            r_show_prev <= 1'b0;
            r_busy      <= 1'b0;
            r_gen_count <= '0;
            r_gen_done  <= 1'b0;
        end else begin
            r_vsync_q   <= i_vsync;
            r_gen_done  <= 1'b0;
            r_step_pend <= w_step_now;
            r_seed_pend <= w_seed_now;

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        if (w_seed_now) begin
                            // Seed wins; the divider holds so a launch due on
                            // this tick is taken on the next one instead.
                            r_state     <= S_SEED;
                            r_seed_pend <= 1'b0;
                            r_gen_count <= '0;
                            r_cell_idx  <= '0;
                            r_seed_we   <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            if (i_run) begin
                                r_div_cnt <= w_div_launch ? '0 : r_div_cnt + 1'b1;
                            end
                            if (w_div_launch || w_step_now) begin
                                r_state     <= S_COPY;
                                r_step_pend <= 1'b0;
                                r_cell_idx  <= '0;
                                r_copy_we   <= 1'b1;
                                r_busy      <= 1'b1;
                            end
                        end
                    end
                end

                S_SEED: begin
                    if (w_last) begin
                        r_state    <= S_IDLE;
                        r_cell_idx <= '0;
                        r_seed_we  <= 1'b0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cell_idx <= r_cell_idx + 1'b1;
                    end
                end

                S_COPY: begin
                    if (w_last) begin
                        // prev is now a full snapshot, so the display can
                        // switch to it while curr is being rewritten.
                        r_state     <= S_EVAL;
                        r_cell_idx  <= '0;
                        r_copy_we   <= 1'b0;
                        r_eval_we   <= 1'b1;
                        r_show_prev <= 1'b1;
                    end else begin
                        r_cell_idx <= r_cell_idx + 1'b1;
                    end
                end

                S_EVAL: begin
                    if (w_last) begin
                        r_state     <= S_IDLE;
                        r_cell_idx  <= '0;
                        r_eval_we   <= 1'b0;
                        r_show_prev <= 1'b0;
                        r_busy      <= 1'b0;
                        r_gen_done  <= 1'b1;
                        r_gen_count <= r_gen_count + 1'b1;
                    end else begin
                        r_cell_idx <= r_cell_idx + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cell_idx  = r_cell_idx;
    assign o_seed_we   = r_seed_we;
    assign o_copy_we   = r_copy_we;
    assign o_eval_we   = r_eval_we;
    assign o_show_prev = r_show_prev;
    assign o_busy      = r_busy;
    assign o_gen_count = r_gen_count;
    assign o_gen_done  = r_gen_done;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// ----------------------------------------------------------------------------
// tb_life_gen_scheduler
//   Directed bench for life_gen_scheduler: seeding after reset, free-running
//   generations, speed divider, single step, long vsync, request priority
//   during a sweep and reset in the middle of a copy sweep.
// ----------------------------------------------------------------------------
module tb_life_gen_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        seed_req = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [5:0]  cell_idx;
    logic        seed_we, copy_we, eval_we, show_prev, busy, gen_done;
    logic [15:0] gen_count;

    int checks = 0;
    int failures = 0;

    // activity counters, sampled on the falling edge
    int   n_seed, n_copy, n_eval, n_done, n_sp_err, n_idx_err;
    logic [5:0] exp_idx = 6'd0;

    always #5 clk = ~clk;

    life_gen_scheduler #(.CELL_BITS(6), .GEN_BITS(16), .DIV_BITS(4)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_vsync    (vsync),
        .i_run      (run),
        .i_step     (step),
        .i_seed_req (seed_req),
        .i_speed    (speed),
        .o_cell_idx (cell_idx),
        .o_seed_we  (seed_we),
        .o_copy_we  (copy_we),
        .o_eval_we  (eval_we),
        .o_show_prev(show_prev),
        .o_busy     (busy),
        .o_gen_count(gen_count),
        .o_gen_done (gen_done)
    );

    always @(negedge clk) begin
        if (seed_we)  n_seed++;
        if (copy_we)  n_copy++;
        if (eval_we)  n_eval++;
        if (gen_done) n_done++;
        if (show_prev !== eval_we) n_sp_err++;
        if (seed_we || copy_we || eval_we) begin
            if (cell_idx !== exp_idx) n_idx_err++;
            exp_idx = exp_idx + 6'd1;
        end else begin
            exp_idx = 6'd0;
            if (cell_idx !== 6'd0) n_idx_err++;
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        n_seed = 0; n_copy = 0; n_eval = 0; n_done = 0;
        n_sp_err = 0; n_idx_err = 0;
    endtask

    // One vsync pulse, then wait (bounded) for any sweep to finish.
    task automatic frame(input int hi);
        int waited;
        vsync = 1'b1;
        cyc(hi);
        vsync = 1'b0;
        cyc(2);
        waited = 0;
        while (busy === 1'b1 && waited < 400) begin
            cyc(1);
            waited++;
        end
        checks++;
        if (waited >= 400) begin
            failures++;
            $display("FAIL frame_timeout busy=%b still high after %0d cycles", busy, waited);
        end
        cyc(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        checks++;
        if ({seed_we, copy_we, eval_we, show_prev, busy, gen_done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {seed_we, copy_we, eval_we, show_prev, busy, gen_done});
        end
        checks++;
        if (cell_idx !== 6'd0) begin
            failures++;
            $display("FAIL reset_cell_idx got=%0d want=0", cell_idx);
        end
        checks++;
        if (gen_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_gen_count got=%0d want=0", gen_count);
        end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_seed_after_reset();
        clr();
        vsync = 1'b1;
        cyc(1);
        checks++;
        if (seed_we !== 1'b1 || cell_idx !== 6'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL seed_latency seed_we=%b idx=%0d busy=%b want 1/0/1",
                     seed_we, cell_idx, busy);
        end
        cyc(3);
        vsync = 1'b0;
        cyc(100);
        checks++;
        if (n_seed != 64 || n_copy != 0 || n_eval != 0 || n_done != 0) begin
            failures++;
            $display("FAIL seed_sweep seed=%0d copy=%0d eval=%0d done=%0d want 64/0/0/0",
                     n_seed, n_copy, n_eval, n_done);
        end
        checks++;
        if (n_idx_err != 0 || gen_count !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL seed_end idx_err=%0d gen_count=%0d busy=%b want 0/0/0",
                     n_idx_err, gen_count, busy);
        end
    endtask

    task automatic test_run_speed0();
        run = 1'b1;
        speed = 4'd0;
        for (int f = 1; f <= 3; f++) begin
            clr();
            frame(4);
            checks++;
            if (n_copy != 64 || n_eval != 64 || n_done != 1 || n_seed != 0) begin
                failures++;
                $display("FAIL run_frame%0d copy=%0d eval=%0d done=%0d seed=%0d want 64/64/1/0",
                         f, n_copy, n_eval, n_done, n_seed);
            end
            checks++;
            if (gen_count !== 16'(f) || n_sp_err != 0 || n_idx_err != 0) begin
                failures++;
                $display("FAIL run_count%0d gen_count=%0d sp_err=%0d idx_err=%0d want %0d/0/0",
                         f, gen_count, n_sp_err, n_idx_err, f);
            end
        end
    endtask

    task automatic test_speed3();
        logic [11:0] mask;
        mask = '0;
        speed = 4'd3;
        for (int t = 0; t < 12; t++) begin
            clr();
            frame(3);
            mask[t] = (n_done == 1);
        end
        checks++;
        if (mask !== 12'b1000_1000_1000) begin
            failures++;
            $display("FAIL speed3_ticks got=%b want=100010001000", mask);
        end
        checks++;
        if (gen_count !== 16'd6) begin
            failures++;
            $display("FAIL speed3_count got=%0d want=6", gen_count);
        end
        run = 1'b0;
        speed = 4'd0;
    endtask

    task automatic test_step();
        logic [2:0] mask;
        mask = '0;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(2);
        for (int t = 0; t < 3; t++) begin
            clr();
            frame(3);
            mask[t] = (n_done == 1);
        end
        checks++;
        if (mask !== 3'b001 || gen_count !== 16'd7) begin
            failures++;
            $display("FAIL step_once mask=%b gen_count=%0d want 001/7", mask, gen_count);
        end
        // long vsync in run mode must still produce a single tick
        run = 1'b1;
        clr();
        frame(1000);
        checks++;
        if (n_done != 1 || gen_count !== 16'd8) begin
            failures++;
            $display("FAIL long_vsync done=%0d gen_count=%0d want 1/8", n_done, gen_count);
        end
        run = 1'b0;
    endtask

    task automatic test_seed_step_in_eval();
        int waited;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        vsync = 1'b1;
        waited = 0;
        while (eval_we !== 1'b1 && waited < 300) begin
            cyc(1);
            waited++;
        end
        checks++;
        if (eval_we !== 1'b1) begin
            failures++;
            $display("FAIL reach_eval eval_we=%b want 1", eval_we);
        end
        cyc(5);
        seed_req = 1'b1;
        step = 1'b1;
        cyc(1);
        seed_req = 1'b0;
        step = 1'b0;
        vsync = 1'b0;
        waited = 0;
        while (busy === 1'b1 && waited < 300) begin
            cyc(1);
            waited++;
        end
        cyc(2);
        checks++;
        if (gen_count !== 16'd9) begin
            failures++;
            $display("FAIL eval_finishes gen_count=%0d want 9", gen_count);
        end
        clr();
        frame(3);
        checks++;
        if (n_seed != 64 || n_copy != 0 || n_done != 0 || gen_count !== 16'd0) begin
            failures++;
            $display("FAIL seed_priority seed=%0d copy=%0d done=%0d gen_count=%0d want 64/0/0/0",
                     n_seed, n_copy, n_done, gen_count);
        end
        clr();
        frame(3);
        checks++;
        if (n_done != 1 || n_seed != 0 || gen_count !== 16'd1) begin
            failures++;
            $display("FAIL step_after_seed done=%0d seed=%0d gen_count=%0d want 1/0/1",
                     n_done, n_seed, gen_count);
        end
    endtask

    task automatic test_reset_mid_copy();
        int waited;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        vsync = 1'b1;
        waited = 0;
        while (!(copy_we === 1'b1 && cell_idx === 6'd20) && waited < 300) begin
            cyc(1);
            waited++;
        end
        checks++;
        if (copy_we !== 1'b1 || cell_idx !== 6'd20) begin
            failures++;
            $display("FAIL reach_copy20 copy_we=%b idx=%0d want 1/20", copy_we, cell_idx);
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        vsync = 1'b0;
        checks++;
        if (copy_we !== 1'b0 || cell_idx !== 6'd0 || busy !== 1'b0 || gen_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_copy copy_we=%b idx=%0d busy=%b gen_count=%0d want 0/0/0/0",
                     copy_we, cell_idx, busy, gen_count);
        end
        cyc(2);
        clr();
        frame(3);
        checks++;
        if (n_seed != 64 || n_copy != 0 || n_eval != 0) begin
            failures++;
            $display("FAIL seed_after_reset seed=%0d copy=%0d eval=%0d want 64/0/0",
                     n_seed, n_copy, n_eval);
        end
    endtask

    initial begin
        clr();
        test_reset();
        test_seed_after_reset();
        test_run_speed0();
        test_speed3();
        test_step();
        test_seed_step_in_eval();
        test_reset_mid_copy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
